// File: rtl/voice_phase_sequencer.sv
// Time-multiplexed phase accumulator for all synth voices.
// One shared adder walks the voices per sample tick and streams phases out.
module voice_phase_sequencer #(
  parameter int NUM_VOICES = 24,
  parameter int PHASE_W    = 32,
  parameter int IDX_W      = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sample_tick_in,
  input  logic [NUM_VOICES-1:0] gate_in,
  input  logic                  cfg_we_in,
  input  logic [IDX_W-1:0]      cfg_addr_in,
  input  logic [PHASE_W-1:0]    cfg_data_in,
  output logic [PHASE_W-1:0]    phase_out,
  output logic [IDX_W-1:0]      voice_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  frame_done_out,
  output logic                  busy_out,
  output logic                  overrun_out
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t               state, state_d;
  logic [IDX_W-1:0]     idx, idx_d, idx_nxt;
  logic [NUM_VOICES-1:0] gate_q;
  logic [PHASE_W-1:0]   phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]   inc_q   [NUM_VOICES];
  logic                 load, clear, emit, adv, last;

  assign last           = (idx == LAST_IDX);
  assign idx_nxt        = idx + IDX_W'(1);
  assign busy_out       = (state != IDLE);
  assign frame_done_out = (state == DONE);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    load    = 1'b0;
    clear   = 1'b0;
    emit    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_tick_in) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (gate_q[idx]) begin
          emit    = 1'b1;
          state_d = EMIT;
        end else begin
          clear = 1'b1;
          if (last) state_d = DONE;
          else      idx_d   = idx_nxt;
        end
      end
      EMIT: begin
        if (valid_out && ready_in) begin
          adv = 1'b1;
          if (last) state_d = DONE;
          else begin
            idx_d   = idx_nxt;
            state_d = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      idx         <= '0;
      gate_q      <= '0;
      phase_out   <= '0;
      voice_out   <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (load) gate_q <= gate_in;
      if (emit) begin
        phase_out <= phase_q[idx];
        voice_out <= idx;
        valid_out <= 1'b1;
      end
      if (adv) valid_out <= 1'b0;
      // Ticks are never queued; a tick during any busy state is lost.
      if (sample_tick_in && state != IDLE) overrun_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else if (clear) begin
      phase_q[idx] <= '0;
    end else if (adv) begin
      phase_q[idx] <= phase_q[idx] + inc_q[idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_VOICES; i++) inc_q[i] <= '0;
    end else if (cfg_we_in && cfg_addr_in <= LAST_IDX) begin
      inc_q[cfg_addr_in] <= cfg_data_in;
    end
  end

endmodule

// File: tb/tb_voice_phase_sequencer.sv
// Bench for voice_phase_sequencer: frame-level model plus directed tests.
// Inputs change 1ns after posedge; the checker samples on negedge.
module tb_voice_phase_sequencer;

  localparam int NV = 24;

  logic          clk = 1'b0;
  logic          rst_in, sample_tick_in, cfg_we_in, ready_in;
  logic [NV-1:0] gate_in;
  logic [4:0]    cfg_addr_in;
  logic [31:0]   cfg_data_in;
  logic [31:0]   phase_out;
  logic [4:0]    voice_out;
  logic          valid_out, frame_done_out, busy_out, overrun_out;

  voice_phase_sequencer dut (
    .clk_in(clk), .rst_in(rst_in), .sample_tick_in(sample_tick_in),
    .gate_in(gate_in), .cfg_we_in(cfg_we_in), .cfg_addr_in(cfg_addr_in),
    .cfg_data_in(cfg_data_in), .phase_out(phase_out),
    .voice_out(voice_out), .valid_out(valid_out), .ready_in(ready_in),
    .frame_done_out(frame_done_out), .busy_out(busy_out),
    .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // frame-level reference model
  logic [31:0] m_phase [NV];
  logic [31:0] m_inc   [NV];
  logic        m_overrun;
  logic [4:0]  exp_v [$];
  logic [31:0] exp_p [$];
  bit          frame_active, started, prev_stall, exp_busy, exp_done;
  int unsigned f_start, done_at, k;
  logic [4:0]  pv;
  logic [31:0] pp;

  // observations shared with the directed tests
  logic [4:0]  log_v [$];
  logic [31:0] log_p [$];
  int unsigned log_c [$];
  int unsigned done_log [$];
  int          done_cnt, stall_cnt;

  task automatic clear_model();
    for (int i = 0; i < NV; i++) begin
      m_phase[i] = '0;
      m_inc[i]   = '0;
    end
    m_overrun    = 1'b0;
    frame_active = 1'b0;
    prev_stall   = 1'b0;
    exp_v.delete();
    exp_p.delete();
  endtask

  always @(negedge clk) begin
    if (!started) begin
      if (rst_in) begin
        started = 1'b1;
        clear_model();
      end
    end else begin
      exp_busy = frame_active && cyc >= f_start && cyc <= done_at;
      exp_done = frame_active && cyc == done_at;
      chk("busy", busy_out, exp_busy);
      chk("frame_done", frame_done_out, exp_done);
      chk("overrun", overrun_out, m_overrun);
      if (!exp_busy) chk("idle_valid", valid_out, 1'b0);
      if (prev_stall) begin
        chk("hold_valid", valid_out, 1'b1);
        chk("hold_voice", voice_out, pv);
        chk("hold_phase", phase_out, pp);
      end
      if (valid_out && ready_in) begin
        if (exp_v.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: unexpected voice %0d phase %0h",
                   voice_out, phase_out);
        end else begin
          chk("beat_voice", voice_out, exp_v.pop_front());
          chk("beat_phase", phase_out, exp_p.pop_front());
        end
        log_v.push_back(voice_out);
        log_p.push_back(phase_out);
        log_c.push_back(cyc);
      end
      prev_stall = valid_out && !ready_in;
      pv = voice_out;
      pp = phase_out;
      if (prev_stall && frame_active) begin
        done_at++;
        stall_cnt++;
      end
      if (exp_done) begin
        done_cnt++;
        done_log.push_back(cyc);
        chk("beats_left", exp_v.size(), 0);
        frame_active = 1'b0;
      end
      if (cfg_we_in && cfg_addr_in < NV) m_inc[cfg_addr_in] = cfg_data_in;
      if (sample_tick_in) begin
        if (exp_busy) m_overrun = 1'b1;
        else begin
          k = 0;
          for (int i = 0; i < NV; i++) begin
            if (gate_in[i]) begin
              exp_v.push_back(5'(i));
              exp_p.push_back(m_phase[i]);
              m_phase[i] = m_phase[i] + m_inc[i];
              k++;
            end else m_phase[i] = '0;
          end
          frame_active = 1'b1;
          f_start = cyc + 1;
          done_at = cyc + 1 + NV + k;
        end
      end
      if (rst_in) clear_model();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [4:0] a, input logic [31:0] d);
    cfg_we_in = 1'b1;
    cfg_addr_in = a;
    cfg_data_in = d;
    step(1);
    cfg_we_in = 1'b0;
  endtask

  task automatic tick_frame(input logic [NV-1:0] g);
    gate_in = g;
    sample_tick_in = 1'b1;
    step(1);
    sample_tick_in = 1'b0;
    step(63);
  endtask

  task automatic clear_log();
    log_v.delete();
    log_p.delete();
    log_c.delete();
    done_log.delete();
    done_cnt = 0;
    stall_cnt = 0;
  endtask

  task automatic chk_beat(input string name, input int i,
                          input logic [4:0] v, input logic [31:0] p);
    if (i >= log_v.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: beat %0d missing, got %0d beats", name, i,
               log_v.size());
    end else begin
      chk({name, "_voice"}, log_v[i], v);
      chk({name, "_phase"}, log_p[i], p);
    end
  endtask

  task automatic wait_valid(input string name);
    int w = 0;
    while (!valid_out && w < 100) begin
      step(1);
      w++;
    end
    chk(name, valid_out, 1'b1);
  endtask

  int unsigned t0;
  int          w;

  initial begin
    rst_in = 1'b1;
    sample_tick_in = 1'b0;
    gate_in = '0;
    cfg_we_in = 1'b0;
    cfg_addr_in = '0;
    cfg_data_in = '0;
    ready_in = 1'b1;
    clear_log();
    step(2);
    rst_in = 1'b0;
    step(2);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_phase", phase_out, 32'd0);
    chk("rst_overrun", overrun_out, 1'b0);

    // single voice, three frames
    cfg(5, 32'd18897);
    clear_log();
    repeat (3) tick_frame(24'h000020);
    chk("t1_beats", log_v.size(), 3);
    chk_beat("t1_b0", 0, 5'd5, 32'd0);
    chk_beat("t1_b1", 1, 5'd5, 32'd18897);
    chk_beat("t1_b2", 2, 5'd5, 32'd37794);
    chk("t1_done_cnt", done_cnt, 3);

    // phase wrap
    cfg(0, 32'h8000_0000);
    clear_log();
    repeat (4) tick_frame(24'h000001);
    chk_beat("t2_b0", 0, 5'd0, 32'h0);
    chk_beat("t2_b1", 1, 5'd0, 32'h8000_0000);
    chk_beat("t2_b2", 2, 5'd0, 32'h0);
    chk_beat("t2_b3", 3, 5'd0, 32'h8000_0000);

    // backpressure on first and last voice
    cfg(2, 32'd100);
    cfg(23, 32'd7);
    clear_log();
    ready_in = 1'b0;
    gate_in = 24'h800004;
    sample_tick_in = 1'b1;
    step(1);
    sample_tick_in = 1'b0;
    wait_valid("t3_valid_seen");
    step(10);
    ready_in = 1'b1;
    w = 0;
    while (done_cnt == 0 && w < 100) begin
      step(1);
      w++;
    end
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_stalls", stall_cnt, 10);
    chk_beat("t3_b0", 0, 5'd2, 32'd0);
    chk_beat("t3_b1", 1, 5'd23, 32'd0);
    chk("t3_done_time", done_log.size() > 0 ? done_log[0] : 0,
        log_c.size() > 1 ? log_c[1] + 1 : 1);
    step(20);

    // gate drop clears phase
    cfg(3, 32'd50);
    clear_log();
    tick_frame(24'h000008);
    tick_frame(24'h000008);
    tick_frame(24'h000000);
    tick_frame(24'h000008);
    chk("t4_beats", log_v.size(), 3);
    chk_beat("t4_b0", 0, 5'd3, 32'd0);
    chk_beat("t4_b1", 1, 5'd3, 32'd50);
    chk_beat("t4_b2", 2, 5'd3, 32'd0);

    // overrun on second tick
    clear_log();
    gate_in = '0;
    sample_tick_in = 1'b1;
    t0 = cyc;
    step(1);
    sample_tick_in = 1'b0;
    step(4);
    sample_tick_in = 1'b1;
    step(1);
    sample_tick_in = 1'b0;
    step(2);
    chk("t5_overrun", overrun_out, 1'b1);
    step(60);
    chk("t5_overrun_sticky", overrun_out, 1'b1);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_done_time", done_log.size() > 0 ? done_log[0] - t0 : 0, 25);

    // reset while stalled in EMIT
    cfg(1, 32'd1000);
    cfg(4, 32'd1000);
    clear_log();
    tick_frame(24'h000012);
    chk_beat("t6_pre0", 0, 5'd1, 32'd0);
    chk_beat("t6_pre1", 1, 5'd4, 32'd0);
    ready_in = 1'b0;
    sample_tick_in = 1'b1;
    step(1);
    sample_tick_in = 1'b0;
    wait_valid("t6_valid_seen");
    chk("t6_stall_voice", voice_out, 5'd1);
    chk("t6_stall_phase", phase_out, 32'd1000);
    rst_in = 1'b1;
    step(1);
    rst_in = 1'b0;
    chk("t6_valid", valid_out, 1'b0);
    chk("t6_busy", busy_out, 1'b0);
    chk("t6_phase", phase_out, 32'd0);
    chk("t6_voice", voice_out, 5'd0);
    chk("t6_overrun", overrun_out, 1'b0);
    chk("t6_done", frame_done_out, 1'b0);
    ready_in = 1'b1;
    step(2);
    clear_log();
    tick_frame(24'h000012);
    chk_beat("t6_b0", 0, 5'd1, 32'd0);
    chk_beat("t6_b1", 1, 5'd4, 32'd0);
    chk("t6_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
